dot_product_result_fifo: RTL and testbench

//  Downstream stage of the MLP dot-product engine. Captures each finished 48-bit dot product
//  (one-cycle o_sum/o_valid pulse, no backpressure). Applies a rounding right shift, then

---
 rtl/dot_product_result_fifo.sv | 128 ++++++++++++
 tb/tb_dot_product_result_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_result_fifo.sv
// Result stage of the MLP dot-product engine: round-shift, saturate to OUT_W,
// then buffer in a first-word-fall-through FIFO with drop accounting on overflow.
module dot_product_result_fifo #(
  parameter int S     = 48,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [S-1:0]             i_sum,
  input  logic                     i_valid,
  output logic [OUT_W-1:0]         o_data,
  output logic                     o_sat,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  input  logic                     i_clr_ovf,
  output logic [15:0]              o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic [S:0] RND = ((S+1)'(1) << SHIFT) >> 1;
  localparam logic signed [S:0] MAX_R = $signed({{(S+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [S:0] MIN_R = $signed({{(S+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}});

  logic signed [S:0]  w_ext;
  logic signed [S:0]  w_rnd;
  logic [OUT_W-1:0]   w_res;
  logic               w_res_sat;

  logic               r_s1_valid;
  logic [OUT_W-1:0]   r_s1_data;
  logic               r_s1_sat;

  logic [OUT_W:0]     r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_level;
  logic               r_overflow;
  logic [15:0]        r_drop_cnt;

  logic               w_pop;
  logic               w_full;
  logic               w_wr;
  logic               w_drop;
  logic [OUT_W:0]     w_head;

  assign w_ext = $signed({i_sum[S-1], i_sum}) + $signed(RND);
  assign w_rnd = w_ext >>> SHIFT;

  always_comb begin
    w_res     = w_rnd[OUT_W-1:0];
    w_res_sat = 1'b0;
    if (w_rnd > MAX_R) begin
      w_res     = {1'b0, {(OUT_W-1){1'b1}}};
      w_res_sat = 1'b1;
    end else if (w_rnd < MIN_R) begin
      w_res     = {1'b1, {(OUT_W-1){1'b0}}};
      w_res_sat = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_sat   <= 1'b0;
    end else begin
      r_s1_valid <= i_valid;
      r_s1_data  <= w_res;
      r_s1_sat   <= w_res_sat;
    end
  end

  // Output handshake: the head entry transfers on any cycle with o_valid & i_ready;
  // while o_valid & !i_ready it holds stable, and i_ready is ignored when o_valid=0.
  assign w_pop  = o_valid & i_ready;
  assign w_full = (r_level == (AW+1)'(DEPTH));
  assign w_wr   = r_s1_valid & (~w_full | w_pop);
  assign w_drop = r_s1_valid & w_full & ~w_pop;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_s1_sat, r_s1_data};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (i_clr_ovf)                r_drop_cnt <= 16'd1;
      else if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign o_valid    = (r_level != '0);
  assign o_data     = o_valid ? w_head[OUT_W-1:0] : '0;
  assign o_sat      = o_valid & w_head[OUT_W];
  assign o_level    = r_level;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_dot_product_result_fifo.sv
// Bench for dot_product_result_fifo: two instances (SHIFT=0 and SHIFT=4) share stimulus
// and are compared every cycle against a queue-based model, plus literal spot checks.
module tb_dot_product_result_fifo;

  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] d0;
    logic        s0;
    logic [31:0] d4;
    logic        s4;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] sum;
  logic        vld;
  logic        rdy;
  logic        clr;

  logic [31:0] o_data0, o_data4;
  logic        o_sat0, o_sat4, o_valid0, o_valid4;
  logic [4:0]  o_level0, o_level4;
  logic        o_ovf0, o_ovf4;
  logic [15:0] o_cnt0, o_cnt4;

  int n_cmp = 0;
  int n_err = 0;

  entry_t      mq[$];
  logic        m_s1_v;
  entry_t      m_s1;
  logic        m_ovf;
  int          m_cnt;

  always #5 clk = ~clk;

  dot_product_result_fifo #(.S(48), .OUT_W(32), .SHIFT(0), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_sum(sum), .i_valid(vld),
    .o_data(o_data0), .o_sat(o_sat0), .o_valid(o_valid0), .i_ready(rdy),
    .o_level(o_level0), .o_overflow(o_ovf0), .i_clr_ovf(clr), .o_drop_cnt(o_cnt0)
  );

  dot_product_result_fifo #(.S(48), .OUT_W(32), .SHIFT(4), .DEPTH(DEPTH)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_sum(sum), .i_valid(vld),
    .o_data(o_data4), .o_sat(o_sat4), .o_valid(o_valid4), .i_ready(rdy),
    .o_level(o_level4), .o_overflow(o_ovf4), .i_clr_ovf(clr), .o_drop_cnt(o_cnt4)
  );

  // Rounded (half toward +inf) arithmetic shift followed by signed 32-bit saturation.
  function automatic logic [32:0] ref_result(logic [47:0] s, int sh);
    longint v;
    longint r;
    v = longint'($signed(s));
    r = v + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0));
    r = r >>> sh;
    if (r > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
    else if (r < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, r[31:0]};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one pipeline slot, then a bounded queue shared by both shift variants.
  always @(posedge clk) begin
    logic pop;
    logic [32:0] r0, r4;
    if (!rst_n) begin
      mq.delete();
      m_s1_v = 1'b0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
    end else begin
      pop = (mq.size() > 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (m_s1_v && (mq.size() < DEPTH || pop)) begin
        mq.push_back(m_s1);
        if (clr) begin m_ovf = 1'b0; m_cnt = 0; end
      end else if (m_s1_v) begin
        m_ovf = 1'b1;
        m_cnt = clr ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
      end else if (clr) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end
      m_s1_v = vld;
      r0 = ref_result(sum, 0);
      r4 = ref_result(sum, 4);
      m_s1.d0 = r0[31:0]; m_s1.s0 = r0[32];
      m_s1.d4 = r4[31:0]; m_s1.s4 = r4[32];
    end
  end

  always @(negedge clk) begin
    if (rst_n !== 1'bx) begin
      check("valid0", 64'(o_valid0), 64'(mq.size() > 0));
      check("valid4", 64'(o_valid4), 64'(mq.size() > 0));
      check("level0", 64'(o_level0), 64'(mq.size()));
      check("level4", 64'(o_level4), 64'(mq.size()));
      check("data0",  64'(o_data0),  (mq.size() > 0) ? 64'(mq[0].d0) : 64'd0);
      check("sat0",   64'(o_sat0),   (mq.size() > 0) ? 64'(mq[0].s0) : 64'd0);
      check("data4",  64'(o_data4),  (mq.size() > 0) ? 64'(mq[0].d4) : 64'd0);
      check("sat4",   64'(o_sat4),   (mq.size() > 0) ? 64'(mq[0].s4) : 64'd0);
      check("ovf",    64'(o_ovf0),   64'(m_ovf));
      check("ovf4",   64'(o_ovf4),   64'(m_ovf));
      check("dropcnt",64'(o_cnt0),   64'(m_cnt));
    end
  end

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(logic [47:0] s);
    vld = 1'b1;
    sum = s;
    step();
    vld = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'bx; sum = '0; vld = 1'b0; rdy = 1'b0; clr = 1'b0;
    step();
    do_reset();
    check("rst_valid", 64'(o_valid0), 64'd0);
    check("rst_data",  64'(o_data0),  64'd0);
    check("rst_level", 64'(o_level0), 64'd0);
    check("rst_cnt",   64'(o_cnt0),   64'd0);

    // basic latency and pass-through
    rdy = 1'b1;
    pulse(48'd1000);
    check("lat1_not_yet", 64'(o_valid0), 64'd0);
    step();
    check("lat2_valid", 64'(o_valid0), 64'd1);
    check("lat2_data",  64'(o_data0),  64'd1000);
    check("lat2_sat",   64'(o_sat0),   64'd0);
    step();
    check("after_pop",  64'(o_valid0), 64'd0);

    // saturation at both ends
    pulse(48'h0001_0000_0000); step();
    check("satp_data", 64'(o_data0), 64'h7FFF_FFFF);
    check("satp_flag", 64'(o_sat0),  64'd1);
    step();
    pulse(48'hFF00_0000_0000); step();
    check("satn_data", 64'(o_data0), 64'h8000_0000);
    check("satn_flag", 64'(o_sat0),  64'd1);
    step();

    // rounding with SHIFT=4
    pulse(48'd24); step();
    check("rnd24", 64'(o_data4), 64'd2);
    check("rnd24_sat", 64'(o_sat4), 64'd0);
    step();
    pulse(-48'sd24); step();
    check("rndm24", 64'(o_data4), 64'hFFFF_FFFF);
    check("rndm24_sat", 64'(o_sat4), 64'd0);
    step();
    pulse(48'd23); step();
    check("rnd23", 64'(o_data4), 64'd1);
    step();

    // overflow: DEPTH+3 back-to-back results with the consumer stalled
    rdy = 1'b0;
    for (int k = 1; k <= DEPTH + 3; k++) begin
      vld = 1'b1; sum = 48'(k); step();
    end
    vld = 1'b0;
    step(2);
    check("full_level", 64'(o_level0), 64'd16);
    check("full_ovf",   64'(o_ovf0),   64'd1);
    check("full_cnt",   64'(o_cnt0),   64'd3);
    step(3);
    check("stall_hold", 64'(o_data0),  64'd1);
    rdy = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      check("drain_order", 64'(o_data0), 64'(k));
      step();
    end
    check("drained", 64'(o_valid0), 64'd0);

    // full with simultaneous write and pop, then clear
    rdy = 1'b0;
    for (int k = 1; k <= DEPTH; k++) pulse(48'(100 + k));
    step(2);
    check("refull_level", 64'(o_level0), 64'd16);
    pulse(48'd500);
    rdy = 1'b1; step(); rdy = 1'b0;
    check("wrpop_level", 64'(o_level0), 64'd16);
    check("wrpop_cnt",   64'(o_cnt0),   64'd3);
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_ovf", 64'(o_ovf0), 64'd0);
    check("clr_cnt", 64'(o_cnt0), 64'd0);
    // drop coinciding with clear: the drop wins
    pulse(48'd600);
    clr = 1'b1; step(); clr = 1'b0;
    check("dropclr_ovf", 64'(o_ovf0), 64'd1);
    check("dropclr_cnt", 64'(o_cnt0), 64'd1);
    rdy = 1'b1; step(DEPTH + 2);

    // reset with buffered and in-flight results
    rdy = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      vld = 1'b1; sum = 48'(k); step();
    end
    vld = 1'b0;
    check("pre_rst_level", 64'(o_level0), 64'd5);
    rst_n = 1'b0; step();
    check("midrst_valid", 64'(o_valid0), 64'd0);
    check("midrst_level", 64'(o_level0), 64'd0);
    rst_n = 1'b1; step(3);
    check("post_rst_valid", 64'(o_valid0), 64'd0);
    check("post_rst_ovf",   64'(o_ovf0),   64'd0);

    // randomized traffic across magnitudes and near saturation boundaries
    for (int i = 0; i < 3000; i++) begin
      vld = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 4))
        0: sum = 48'($urandom_range(0, 1000)) - 48'd500;
        1: sum = {$urandom(), $urandom()} >> 16;
        2: sum = 48'h0000_7FFF_FFF0 + 48'($urandom_range(0, 31));
        3: sum = 48'hFFFF_8000_0010 - 48'($urandom_range(0, 31));
        default: sum = 48'h0007_FFFF_FFE0 + 48'($urandom_range(0, 63));
      endcase
      rdy = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 25));
      clr = ($urandom_range(0, 99) < 3);
      if (i == 2500) rst_n = 1'b0;
      else           rst_n = 1'b1;
      step();
    end
    vld = 1'b0; clr = 1'b0; rdy = 1'b1; rst_n = 1'b1;
    step(DEPTH + 4);
    check("final_empty", 64'(o_valid0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
